// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the MIPS execute stage.
//   - ALU control code constants driven by the ALU control decoder
//   - state encoding for the optional iterative multiplier (EX_STAGE_MUL_EN)
//   - bubble/reset values for the EX/MEM control bundle
package ex_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Control bits carried through EX/MEM.
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } exmem_ctrl_t;

    localparam exmem_ctrl_t CTRL_BUBBLE = '{valid: 1'b0, reg_write: 1'b0,
                                            mem_read: 1'b0, mem_write: 1'b0};
    localparam logic [4:0]  RD_BUBBLE   = 5'd0;

    function automatic logic is_mul(input logic [3:0] ctrl);
        return ctrl == ALU_MUL;
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU for the execute stage.
// Ports:
//   i_alu_ctrl  4-bit ALU control code (see ex_pkg)
//   i_op_a/b    operands
//   o_result    ALU result (0 for unlisted codes, including MUL which is
//               handled by the iterative multiplier in ex_stage)
//   o_zero      o_result == 0
module alu_core
    import ex_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_alu_ctrl,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero
);

    logic [WIDTH-1:0] w_result;

    always_comb begin
        w_result = '0;
        case (i_alu_ctrl)
            ALU_AND: w_result = i_op_a & i_op_b;
            ALU_OR:  w_result = i_op_a | i_op_b;
            ALU_ADD: w_result = i_op_a + i_op_b;   // wraps, no overflow trap
            ALU_SUB: w_result = i_op_a - i_op_b;
            ALU_SLT: w_result = {{(WIDTH-1){1'b0}},
                                 ($signed(i_op_a) < $signed(i_op_b))};
            default: w_result = '0;
        endcase
    end

    assign o_result = w_result;
    assign o_zero   = (w_result == '0);

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the pipelined MIPS core.
// Runs the ALU on ID/EX operands and registers the result plus pass-through
// controls into EX/MEM. Supports flush (bubble) and stall (hold) from the
// hazard unit.
// Optional feature: define EX_STAGE_MUL_EN to add an iterative shift-add
// multiplier (ALU code 1000, low WIDTH bits of the unsigned product, one
// bit per cycle). While it runs, ex_busy asks upstream to stall.
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   in_valid, alu_ctrl, op_a, op_b    ID/EX instruction and operands
//   store_data, rd_addr               sw data, destination register
//   reg_write, mem_read, mem_write    pass-through controls
//   stall_in, flush                   hazard unit controls (flush wins)
//   ex_zero                           combinational ALU result == 0
//   ex_busy                           combinational upstream stall request
//   exmem_*                           registered EX/MEM pipeline outputs
module ex_stage
    import ex_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] store_data,
    input  logic [4:0]       rd_addr,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             stall_in,
    input  logic             flush,
    output logic             ex_zero,
    output logic             ex_busy,
    output logic             exmem_valid,
    output logic             exmem_reg_write,
    output logic             exmem_mem_read,
    output logic             exmem_mem_write,
    output logic [WIDTH-1:0] exmem_result,
    output logic [WIDTH-1:0] exmem_store_data,
    output logic [4:0]       exmem_rd
);

    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_zero;
    logic [WIDTH-1:0] w_result;
    logic             w_busy;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .i_alu_ctrl (alu_ctrl),
        .i_op_a     (op_a),
        .i_op_b     (op_b),
        .o_result   (w_alu_result),
        .o_zero     (w_alu_zero)
    );

    assign ex_zero = w_alu_zero;

`ifdef EX_STAGE_MUL_EN
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_e       r_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;

    assign w_accept = (r_state == IDLE) && in_valid && is_mul(alu_ctrl) && !flush;

    // Busy through accept and all iterations; in DONE only while the product
    // cannot drain, so upstream advances on the same edge EX/MEM loads it.
    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            IDLE:    w_busy = w_accept;
            MUL:     w_busy = 1'b1;
            DONE:    w_busy = stall_in;
            default: w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (flush) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= op_a;
                        r_mplier <= op_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= MUL;
                    end
                end
                MUL: begin
                    // One multiplier bit per edge; only the low WIDTH bits
                    // of the product are kept, so mcand may shift out.
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH-1)) r_state <= DONE;
                end
                DONE: begin
                    if (!stall_in) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_result = (r_state == DONE) ? r_acc : w_alu_result;
`else
    assign w_busy   = 1'b0;
    assign w_result = w_alu_result;
`endif

    assign ex_busy = w_busy;

    // EX/MEM pipeline register: reset > flush > hold > load.
    exmem_ctrl_t      r_ctrl;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_store_data;
    logic [4:0]       r_rd;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_ctrl       <= CTRL_BUBBLE;
            r_result     <= '0;
            r_store_data <= '0;
            r_rd         <= RD_BUBBLE;
        end else if (!(stall_in || w_busy)) begin
            // An invalid ID/EX entry loads as a bubble: all controls low.
            r_ctrl.valid     <= in_valid;
            r_ctrl.reg_write <= in_valid & reg_write;
            r_ctrl.mem_read  <= in_valid & mem_read;
            r_ctrl.mem_write <= in_valid & mem_write;
            r_result         <= w_result;
            r_store_data     <= store_data;
            r_rd             <= rd_addr;
        end
    end

    assign exmem_valid      = r_ctrl.valid;
    assign exmem_reg_write  = r_ctrl.reg_write;
    assign exmem_mem_read   = r_ctrl.mem_read;
    assign exmem_mem_write  = r_ctrl.mem_write;
    assign exmem_result     = r_result;
    assign exmem_store_data = r_store_data;
    assign exmem_rd         = r_rd;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage.
// Multiplier scenarios are compiled in only when EX_STAGE_MUL_EN is defined.
module tb_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a, op_b, store_data;
    logic [4:0]  rd_addr;
    logic        reg_write, mem_read, mem_write;
    logic        stall_in, flush;
    logic        ex_zero, ex_busy;
    logic        exmem_valid, exmem_reg_write, exmem_mem_read, exmem_mem_write;
    logic [31:0] exmem_result, exmem_store_data;
    logic [4:0]  exmem_rd;

    int checks = 0;
    int errors = 0;

    ex_stage #(.WIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .alu_ctrl         (alu_ctrl),
        .op_a             (op_a),
        .op_b             (op_b),
        .store_data       (store_data),
        .rd_addr          (rd_addr),
        .reg_write        (reg_write),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .stall_in         (stall_in),
        .flush            (flush),
        .ex_zero          (ex_zero),
        .ex_busy          (ex_busy),
        .exmem_valid      (exmem_valid),
        .exmem_reg_write  (exmem_reg_write),
        .exmem_mem_read   (exmem_mem_read),
        .exmem_mem_write  (exmem_mem_write),
        .exmem_result     (exmem_result),
        .exmem_store_data (exmem_store_data),
        .exmem_rd         (exmem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic rw);
        in_valid  = v;
        alu_ctrl  = c;
        op_a      = a;
        op_b      = b;
        rd_addr   = rd;
        reg_write = rw;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; stall_in = 1'b0; flush = 1'b0; store_data = 32'h1234_5678;
        drive(1'b1, 4'b0010, 32'h11, 32'h22, 5'd9, 1'b1);
        mem_read = 1'b1; mem_write = 1'b1;
        step(); step();
        chk("rst_valid",  {31'd0, exmem_valid},     32'd0);
        chk("rst_rw",     {31'd0, exmem_reg_write}, 32'd0);
        chk("rst_mr",     {31'd0, exmem_mem_read},  32'd0);
        chk("rst_mw",     {31'd0, exmem_mem_write}, 32'd0);
        chk("rst_result", exmem_result,             32'd0);
        chk("rst_store",  exmem_store_data,         32'd0);
        chk("rst_rd",     {27'd0, exmem_rd},        32'd0);
        chk("rst_busy",   {31'd0, ex_busy},         32'd0);
        rst_n = 1'b1;

        // ADD wraps into the sign bit
        drive(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd5, 1'b1);
        #1 chk("add_zero", {31'd0, ex_zero}, 32'd0);
        step();
        chk("add_result", exmem_result,             32'h8000_0000);
        chk("add_valid",  {31'd0, exmem_valid},     32'd1);
        chk("add_rw",     {31'd0, exmem_reg_write}, 32'd1);
        chk("add_rd",     {27'd0, exmem_rd},        32'd5);

        // SUB 5-5: ex_zero visible before the edge
        drive(1'b1, 4'b0110, 32'd5, 32'd5, 5'd6, 1'b1);
        #1 chk("sub_zero_comb", {31'd0, ex_zero}, 32'd1);
        step();
        chk("sub_result", exmem_result, 32'd0);

        // SLT signed: -1 < 1, and 1 < -1 is false
        drive(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd7, 1'b1);
        step();
        chk("slt_neg", exmem_result, 32'd1);
        drive(1'b1, 4'b0111, 32'd1, 32'hFFFF_FFFF, 5'd7, 1'b1);
        step();
        chk("slt_pos", exmem_result, 32'd0);

        drive(1'b1, 4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 5'd8, 1'b1);
        step();
        chk("and_result", exmem_result, 32'h0000_00F0);
        drive(1'b1, 4'b0001, 32'h0000_F0F0, 32'h0000_0FF0, 5'd8, 1'b1);
        step();
        chk("or_result", exmem_result, 32'h0000_FFF0);

        // Unlisted code gives 0 (and ex_zero still driven)
        drive(1'b1, 4'b0101, 32'h0000_F0F0, 32'h0000_0FF0, 5'd8, 1'b1);
        #1 chk("unlisted_zero", {31'd0, ex_zero}, 32'd1);
        step();
        chk("unlisted_result", exmem_result, 32'd0);

`ifndef EX_STAGE_MUL_EN
        // Without the multiplier, 1000 is just another unlisted op
        drive(1'b1, 4'b1000, 32'd123, 32'd456, 5'd3, 1'b1);
        #1 chk("nomul_busy", {31'd0, ex_busy}, 32'd0);
        step();
        chk("nomul_result", exmem_result,         32'd0);
        chk("nomul_valid",  {31'd0, exmem_valid}, 32'd1);
`endif

        // in_valid=0 loads a bubble even with controls high
        drive(1'b0, 4'b0010, 32'd1, 32'd2, 5'd4, 1'b1);
        mem_read = 1'b1;
        step();
        chk("bub_valid", {31'd0, exmem_valid},     32'd0);
        chk("bub_rw",    {31'd0, exmem_reg_write}, 32'd0);
        chk("bub_mr",    {31'd0, exmem_mem_read},  32'd0);

        // sw then stall for 3 cycles with different inputs
        drive(1'b1, 4'b0010, 32'd100, 32'd8, 5'd0, 1'b0);
        mem_write = 1'b1; store_data = 32'hDEAD_BEEF;
        step();
        chk("sw_result", exmem_result,             32'd108);
        chk("sw_store",  exmem_store_data,         32'hDEAD_BEEF);
        chk("sw_mw",     {31'd0, exmem_mem_write}, 32'd1);
        drive(1'b1, 4'b0001, 32'hAAAA_0000, 32'h0000_5555, 5'd12, 1'b1);
        store_data = 32'h0; stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_result", exmem_result,             32'd108);
            chk("stall_mw",     {31'd0, exmem_mem_write}, 32'd1);
            chk("stall_store",  exmem_store_data,         32'hDEAD_BEEF);
        end

        // flush beats stall
        flush = 1'b1;
        step();
        chk("flush_valid",  {31'd0, exmem_valid},     32'd0);
        chk("flush_mw",     {31'd0, exmem_mem_write}, 32'd0);
        chk("flush_result", exmem_result,             32'd0);
        flush = 1'b0; stall_in = 1'b0;

`ifdef EX_STAGE_MUL_EN
        // MUL 123*456: count busy cycles starting with the accept cycle
        drive(1'b1, 4'b1000, 32'd123, 32'd456, 5'd10, 1'b1);
        #1 chk("mul_busy_accept", {31'd0, ex_busy}, 32'd1);
        n = 0;
        while (ex_busy && n < 100) begin
            step();
            n++;
        end
        chk("mul_busy_cycles", n, 32'd33);
        step();
        chk("mul_result", exmem_result,         32'd56088);
        chk("mul_valid",  {31'd0, exmem_valid}, 32'd1);

        // 0xFFFFFFFF*2 with stall held through DONE
        drive(1'b1, 4'b1000, 32'hFFFF_FFFF, 32'd2, 5'd11, 1'b1);
        stall_in = 1'b1;
        repeat (33) step();
        chk("mul_done_busy", {31'd0, ex_busy}, 32'd1);
        chk("mul_done_held", exmem_result,     32'd56088);
        step();
        chk("mul_done_held2", exmem_result, 32'd56088);
        stall_in = 1'b0;
        #1 chk("mul_done_release", {31'd0, ex_busy}, 32'd0);
        step();
        chk("mul_wrap_result", exmem_result, 32'hFFFF_FFFE);

        // flush at iteration 10
        drive(1'b1, 4'b1000, 32'd7, 32'd9, 5'd1, 1'b1);
        step();
        repeat (10) step();
        chk("mul_flush_busy_before", {31'd0, ex_busy}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 4'b0010, 32'd0, 32'd0, 5'd0, 1'b0);
        #1;
        chk("mul_flush_busy",  {31'd0, ex_busy},     32'd0);
        chk("mul_flush_valid", {31'd0, exmem_valid}, 32'd0);

        // reset mid-MUL
        drive(1'b1, 4'b1000, 32'd3, 32'd5, 5'd2, 1'b1);
        repeat (6) step();
        rst_n = 1'b0;
        drive(1'b0, 4'b0010, 32'd0, 32'd0, 5'd0, 1'b0);
        step();
        chk("mul_rst_busy",  {31'd0, ex_busy},     32'd0);
        chk("mul_rst_valid", {31'd0, exmem_valid}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("mul_rst_after", {31'd0, ex_busy}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
